// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO and sequencer driving a combinational 4-bit ALU
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake; cmd_op/cmd_a/cmd_b carry the command
//   alu_a/alu_b/alu_s       registered operands and opcode driven to the ALU
//   alu_y                   ALU result, sampled after the settle time
//   rsp_valid/rsp_ready     response handshake; rsp_y/rsp_op/rsp_err carry the result
//   busy                    a command is in flight or buffered
//   err_cnt                 saturating count of divide/modulo-by-zero results

module alu_cmd_sequencer #(
    parameter int DEPTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_s,
    input  logic [3:0] alu_y,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_y,
    output logic [3:0] rsp_op,
    output logic       rsp_err,
    output logic       busy,
    output logic [7:0] err_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_MOD = 4'b0100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [11:0]   fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] settle_cnt;

    logic        push;
    logic        pop;
    logic        capture;
    logic        rsp_done;
    logic        div_zero;
    logic [11:0] head;

    // Ready depends on occupancy alone, so a full FIFO refuses even while popping.
    assign cmd_ready = (count < DEPTH_C);
    assign push      = cmd_valid && cmd_ready;
    assign head      = fifo_mem[rd_ptr];
    assign busy      = (state != ST_IDLE) || (count != '0);
    assign div_zero  = ((alu_s == OP_DIV) || (alu_s == OP_MOD)) && (alu_b == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pops happen only on transitions into DRIVE, either from IDLE or
    // straight out of RESP when the response is taken and work is queued.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        capture    = 1'b0;
        rsp_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    capture    = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_valid && rsp_ready) begin
                    rsp_done = 1'b1;
                    if (count != '0) begin
                        pop        = 1'b1;
                        state_next = ST_DRIVE;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Storage array carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            alu_s      <= 4'd0;
            settle_cnt <= '0;
        end else begin
            if (pop) begin
                alu_s      <= head[11:8];
                alu_a      <= head[7:4];
                alu_b      <= head[3:0];
                settle_cnt <= '0;
            end else if (state == ST_DRIVE) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_y     <= 4'd0;
            rsp_op    <= 4'd0;
            rsp_err   <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            if (capture) begin
                rsp_valid <= 1'b1;
                rsp_op    <= alu_s;
                rsp_err   <= div_zero;
                // A zero divisor makes the ALU output meaningless; report zero.
                rsp_y     <= div_zero ? 4'd0 : alu_y;
                if (div_zero && (err_cnt != 8'hFF)) begin
                    err_cnt <= err_cnt + 1'b1;
                end
            end else if (rsp_done) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
